// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - Instruction fetch: PC, single-outstanding imem read, valid/ready output register
// Define HALT_DETECT_EN to stop fetching after a HALT_OPCODE word is loaded.
module instr_fetch_stage #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {S_FETCH, S_FULL, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_FULL} state_t;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_instr;
    logic [ADDR_W-1:0] r_out_pc;
    logic              w_room;
    logic              w_req;
    logic              w_load;

    assign w_room = !r_out_valid || out_ready;

    // The request is gated by rst_n so a reset drops it in the same instant.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            S_FETCH: w_req = w_room;
            S_FULL:  w_req = out_ready;
            default: w_req = 1'b0;
        endcase
        if (!rst_n) begin
            w_req = 1'b0;
        end
    end

    assign w_load    = w_req && imem_ack && !redirect_valid;
    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;

`ifdef HALT_DETECT_EN
    logic r_halted;
    logic w_is_halt;
    assign w_is_halt = (imem_rdata[DATA_W-1 -: 4] == HALT_OPCODE);
    assign halted    = r_halted;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
`ifdef HALT_DETECT_EN
            r_halted    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            r_state     <= S_FETCH;
            r_pc        <= redirect_pc;
            r_out_valid <= 1'b0;
`ifdef HALT_DETECT_EN
            r_halted    <= 1'b0;
`endif
        end else if (w_load) begin
            r_out_instr <= imem_rdata;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
`ifdef HALT_DETECT_EN
            if (w_is_halt) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
            end else begin
                r_state <= S_FETCH;
                r_pc    <= r_pc + 1'b1;
            end
`else
            r_state <= S_FETCH;
            r_pc    <= r_pc + 1'b1;
`endif
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_FETCH: if (r_out_valid && !out_ready) r_state <= S_FULL;
                S_FULL:  if (out_ready) r_state <= S_FETCH;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - Scoreboard bench for instr_fetch_stage with a latency-randomized memory model
module tb_instr_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;

    instr_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    int         checks = 0;
    int         errors = 0;
    int         n_xfer = 0;
    int         lat_mode = 0;
    int         mem_cnt = 0;
    bit         mem_busy = 0;
    bit         mon_en = 0;
    bit         stopped = 0;
    bit         redir_pending = 0;
    logic [7:0] redir_tgt;
    logic [7:0] next_push;
    logic [7:0] exp_q[$];

    bit          p_hold = 0;
    bit          p_wait = 0;
    logic [7:0]  h_pc;
    logic [15:0] h_instr;
    logic [7:0]  w_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return (a == 8'h05) ? 16'hF000 : (16'h1000 + {8'h00, a});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The expected stream is the program order from the last reset/redirect target.
    task automatic topup();
        while (!stopped && exp_q.size() < 8) begin
            exp_q.push_back(next_push);
`ifdef HALT_DETECT_EN
            begin
                logic [15:0] w;
                w = mem_word(next_push);
                if (w[15:12] == 4'hF) stopped = 1;
            end
`endif
            next_push = next_push + 8'd1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        redirect_valid = 1'b0;
        if (redir_pending) begin
            exp_q.delete();
            next_push     = redir_tgt;
            stopped       = 0;
            redir_pending = 0;
        end
        topup();
    endtask

    task automatic do_redirect(input logic [7:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        redir_tgt      = pc;
        redir_pending  = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en         = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redir_pending  = 0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_addr", imem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        next_push = 8'h00;
        stopped   = 0;
        topup();
        mon_en = 1;
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst_n || !imem_req) begin
            imem_ack   = 1'b0;
            mem_busy   = 0;
            imem_rdata = 16'($urandom);
        end else begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_busy   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'($urandom);
                mem_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (!mon_en) begin
            p_hold = 0;
            p_wait = 0;
        end else begin
            if (p_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_pc", out_pc, h_pc);
                chk("hold_instr", out_instr, h_instr);
            end
            if (p_wait) begin
                chk("wait_req", imem_req, 1);
                chk("wait_addr", imem_addr, w_addr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected: got pc %0h expected no transfer", out_pc);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("xfer_pc", out_pc, e);
                    chk("xfer_instr", out_instr, mem_word(e));
                    n_xfer++;
                end
            end
            p_hold  = out_valid && !out_ready && !redirect_valid;
            h_pc    = out_pc;
            h_instr = out_instr;
            p_wait  = imem_req && !imem_ack && !redirect_valid;
            w_addr  = imem_addr;
        end
    end

    initial begin
        rst_n          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        redir_tgt      = 8'h00;
        next_push      = 8'h00;
        imem_ack       = 1'b0;
        imem_rdata     = 16'h0000;

        // zero-wait streaming
        lat_mode = 0;
        do_reset();
        #3;
        chk("first_req", imem_req, 1);
        chk("first_valid_lat", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            #3;
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, i);
            chk("stream_instr", out_instr, 16'h1000 + i);
        end

        // stall after first word, then slow memory
        out_ready = 1'b0;
        do_reset();
        #3;
        chk("stall_first_req", imem_req, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #3;
            chk("stall_valid", out_valid, 1);
            chk("stall_instr", out_instr, 16'h1000);
            chk("stall_req", imem_req, 0);
        end
        cyc();
        out_ready = 1'b1;
        lat_mode  = 3;
        #3;
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #3;
            chk("slow_addr", imem_addr, 1);
            chk("slow_empty", out_valid, 0);
        end
        cyc();
        #3;
        chk("slow_valid", out_valid, 1);
        chk("slow_pc", out_pc, 1);
        chk("slow_next_addr", imem_addr, 2);

        // redirect colliding with an ack
        lat_mode = 0;
        do_reset();
        cyc();
        cyc();
        do_redirect(8'h40);
        #3;
        chk("rd_ack_same_cycle", imem_ack, 1);
        cyc();
        #3;
        chk("rd_flush", out_valid, 0);
        chk("rd_addr", imem_addr, 8'h40);

        // PC wrap
        cyc();
        do_redirect(8'hFF);
        cyc();
        cyc();
        #3;
        chk("wrap_ff", out_pc, 8'hFF);
        cyc();
        #3;
        chk("wrap_00", out_pc, 8'h00);
        cyc();
        #3;
        chk("wrap_01", out_pc, 8'h01);

        // halt opcode at address 5
        cyc();
        do_redirect(8'h03);
        cyc();
        cyc();
        cyc();
        cyc();
        #3;
        chk("halt_word_pc", out_pc, 5);
        chk("halt_word_instr", out_instr, 16'hF000);
`ifdef HALT_DETECT_EN
        chk("halted_set", halted, 1);
        chk("halt_no_req", imem_req, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            #3;
            chk("halt_stay", halted, 1);
            chk("halt_drained", out_valid, 0);
            chk("halt_no_req2", imem_req, 0);
        end
        cyc();
        do_redirect(8'h00);
        cyc();
        #3;
        chk("halt_exit", halted, 0);
        chk("halt_exit_req", imem_req, 1);
        chk("halt_exit_addr", imem_addr, 0);
`else
        chk("nohalt_flag", halted, 0);
        chk("nohalt_req", imem_req, 1);
        chk("nohalt_addr", imem_addr, 6);
        cyc();
        #3;
        chk("nohalt_next_pc", out_pc, 6);
`endif

        // randomized traffic
        lat_mode = -1;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                do_reset();
            end else begin
                cyc();
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) do_redirect(8'($urandom));
            end
        end
        cyc();
        out_ready = 1'b1;
        repeat (10) cyc();
        mon_en = 0;

        checks++;
        if (n_xfer < 200) begin
            errors++;
            $display("FAIL progress: got %0d transfers expected at least 200", n_xfer);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
